// File: rtl/crc_bit_serializer_pkg.sv
// Types shared by the byte-to-bit serializer and the serial CRC engine.
package crc_bit_serializer_pkg;

  localparam int unsigned CRC_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } ser_state_e;

  typedef struct packed {
    logic                  last;
    logic [CRC_DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/crc_sync_fifo.sv
// Single-clock show-ahead FIFO; pushes while full and pops while empty are dropped.
module crc_sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage carries no reset; occupancy tracking alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/crc_bit_serializer.sv
// Buffers framed words and emits them MSB-first, one bit per clock, with a
// forced idle gap after each frame so the downstream CRC can publish its result.
module crc_bit_serializer
  import crc_bit_serializer_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          s_valid,
  input  logic                          s_last,
  output logic                          s_ready,
  output logic                          bit_out,
  output logic                          bit_valid,
  output logic                          frame_end,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned ENTRY_W = DATA_W + 1;
  localparam int unsigned CNT_W   = $clog2(DATA_W + 1);
  localparam int unsigned GAP_W   = $clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  ser_state_e          state, state_d;
  logic [DATA_W-1:0]   shreg, shreg_d;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_d;
  logic [GAP_W-1:0]    gap_cnt, gap_cnt_d;
  logic                cur_last, cur_last_d;
  logic                bit_out_d, bit_valid_d, frame_end_d;

  logic                pop;
  logic                load;
  logic [ENTRY_W-1:0]  fifo_rd;
  logic                fifo_full;
  logic                fifo_empty;
  logic [DATA_W-1:0]   rd_word;
  logic                rd_last;

  assign rd_word = fifo_rd[DATA_W-1:0];
  assign rd_last = fifo_rd[DATA_W];
  assign s_ready = !fifo_full;
  assign busy    = (state != ST_IDLE) || !fifo_empty;

  crc_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (s_valid),
    .wr_data ({s_last, s_data}),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // shreg holds the bits still to be shown; bit_out always presents the current bit.
  always_comb begin
    state_d     = state;
    shreg_d     = shreg;
    bit_cnt_d   = bit_cnt;
    gap_cnt_d   = gap_cnt;
    cur_last_d  = cur_last;
    bit_out_d   = 1'b0;
    bit_valid_d = 1'b0;
    frame_end_d = 1'b0;
    load        = 1'b0;
    pop         = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      ST_SHIFT: begin
        if (bit_cnt != '0) begin
          bit_out_d   = shreg[DATA_W-1];
          bit_valid_d = 1'b1;
          frame_end_d = cur_last && (bit_cnt == CNT_W'(1));
          shreg_d     = shreg << 1;
          bit_cnt_d   = bit_cnt - CNT_W'(1);
        end else if (cur_last) begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LOAD;
        end else if (!fifo_empty) begin
          load = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) state_d = ST_IDLE;
        else               gap_cnt_d = gap_cnt - GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    // Popping a word presents its MSB on the very next edge, so words chain without a bubble.
    if (load) begin
      pop         = 1'b1;
      state_d     = ST_SHIFT;
      bit_out_d   = rd_word[DATA_W-1];
      bit_valid_d = 1'b1;
      frame_end_d = rd_last && (CNT_LOAD == '0);
      shreg_d     = rd_word << 1;
      bit_cnt_d   = CNT_LOAD;
      cur_last_d  = rd_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      cur_last  <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      state     <= state_d;
      shreg     <= shreg_d;
      bit_cnt   <= bit_cnt_d;
      gap_cnt   <= gap_cnt_d;
      cur_last  <= cur_last_d;
      bit_out   <= bit_out_d;
      bit_valid <= bit_valid_d;
      frame_end <= frame_end_d;
    end
  end

endmodule

// File: tb/tb_crc_bit_serializer.sv
// Directed self-checking bench for crc_bit_serializer; inputs change and outputs
// are sampled on the falling edge.
module tb_crc_bit_serializer;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned GAP_CYCLES = 2;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [DATA_W-1:0]             s_data;
  logic                          s_valid;
  logic                          s_last;
  logic                          s_ready;
  logic                          bit_out;
  logic                          bit_valid;
  logic                          frame_end;
  logic                          busy;
  logic [$clog2(FIFO_DEPTH):0]   fifo_level;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  crc_bit_serializer #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .frame_end  (frame_end),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  task automatic drive_idle();
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    #1;
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
    n_cmp++; if (bit_out !== 1'b0) begin n_err++; $display("FAIL reset_bit_out: got %b want 0", bit_out); end
    n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL reset_bit_valid: got %b want 0", bit_valid); end
    n_cmp++; if (frame_end !== 1'b0) begin n_err++; $display("FAIL reset_frame_end: got %b want 0", frame_end); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({bit_valid, busy} !== 2'b00) begin n_err++; $display("FAIL post_reset_idle: got valid/busy=%b want 00", {bit_valid, busy}); end
  endtask

  task automatic test_single_word();
    logic [7:0] w;
    logic [2:0] obs, exp_v;
    w = 8'hA5;
    s_valid = 1'b1; s_data = w; s_last = 1'b1;
    @(negedge clk);
    drive_idle();
    n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL single_latency: got valid=%b want 0", bit_valid); end
    n_cmp++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL single_level: got %0d want 1", fifo_level); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      obs = {bit_valid, bit_out, frame_end};
      exp_v = {1'b1, w[7-i], (i == 7)};
      n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL single_bit%0d: got v/b/fe=%b want %b", i, obs, exp_v); end
    end
    for (int g = 0; g < int'(GAP_CYCLES); g++) begin
      @(negedge clk);
      obs = {bit_valid, bit_out, frame_end};
      n_cmp++; if (obs !== 3'b000) begin n_err++; $display("FAIL single_gap%0d: got v/b/fe=%b want 000", g, obs); end
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_done_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    logic [2:0]  obs, exp_v;
    w = 16'hA53C;
    s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b0;
    @(negedge clk);
    s_data = 8'h3C; s_last = 1'b1;
    @(negedge clk);
    drive_idle();
    n_cmp++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL b2b_push_pop_level: got %0d want 1", fifo_level); end
    for (int i = 0; i < 16; i++) begin
      if (i != 0) @(negedge clk);
      obs = {bit_valid, bit_out, frame_end};
      exp_v = {1'b1, w[15-i], (i == 15)};
      n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL b2b_bit%0d: got v/b/fe=%b want %b", i, obs, exp_v); end
    end
    for (int g = 0; g < int'(GAP_CYCLES); g++) begin
      @(negedge clk);
      obs = {bit_valid, bit_out, frame_end};
      n_cmp++; if (obs !== 3'b000) begin n_err++; $display("FAIL b2b_gap%0d: got v/b/fe=%b want 000", g, obs); end
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_done_busy: got %b want 0", busy); end
  endtask

  task automatic test_underrun();
    logic [7:0] w1, w2;
    logic [2:0] obs, exp_v;
    w1 = 8'hA5;
    w2 = 8'h3C;
    s_valid = 1'b1; s_data = w1; s_last = 1'b0;
    @(negedge clk);
    drive_idle();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      obs = {bit_valid, bit_out, frame_end};
      exp_v = {1'b1, w1[7-i], 1'b0};
      n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL under_w1_bit%0d: got v/b/fe=%b want %b", i, obs, exp_v); end
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      obs = {bit_valid, bit_out, frame_end};
      n_cmp++; if (obs !== 3'b000) begin n_err++; $display("FAIL under_hole%0d: got v/b/fe=%b want 000", c, obs); end
    end
    s_valid = 1'b1; s_data = w2; s_last = 1'b1;
    @(negedge clk);
    drive_idle();
    n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL under_resume_latency: got valid=%b want 0", bit_valid); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      obs = {bit_valid, bit_out, frame_end};
      exp_v = {1'b1, w2[7-i], (i == 7)};
      n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL under_w2_bit%0d: got v/b/fe=%b want %b", i, obs, exp_v); end
    end
    for (int g = 0; g < int'(GAP_CYCLES); g++) begin
      @(negedge clk);
      n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL under_gap%0d: got valid=%b want 0", g, bit_valid); end
    end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL under_done_busy: got %b want 0", busy); end
  endtask

  task automatic test_fifo_full();
    logic [7:0]  words [6];
    logic [47:0] exp_bits, got;
    bit          stall_seen;
    int          nbits, fe_cnt, fe_idx, first_cyc, last_cyc;
    words[0] = 8'h81; words[1] = 8'h42; words[2] = 8'h24;
    words[3] = 8'h18; words[4] = 8'hF0; words[5] = 8'h0F;
    exp_bits = 48'h8142_2418_F00F;
    got = '0; stall_seen = 1'b0;
    nbits = 0; fe_cnt = 0; fe_idx = -1; first_cyc = -1; last_cyc = -1;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          bit accepted;
          int tries;
          accepted = 1'b0;
          tries = 0;
          s_valid = 1'b1; s_data = words[k]; s_last = (k == 5);
          while (!accepted && tries < 50) begin
            if (s_ready) begin
              accepted = 1'b1;
            end else if (!stall_seen) begin
              stall_seen = 1'b1;
              n_cmp++; if (fifo_level !== 3'd4) begin n_err++; $display("FAIL full_stall_level: got %0d want 4", fifo_level); end
            end
            @(negedge clk);
            tries++;
          end
          n_cmp++; if (!accepted) begin n_err++; $display("FAIL full_push%0d_timeout: got not accepted want accepted", k); end
        end
        drive_idle();
      end
      begin
        int cyc;
        cyc = 0;
        while (nbits < 48 && cyc < 400) begin
          @(negedge clk);
          cyc++;
          if (bit_valid) begin
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            got = {got[46:0], bit_out};
            if (frame_end) begin fe_cnt++; fe_idx = nbits; end
            nbits++;
          end
        end
      end
    join
    n_cmp++; if (nbits !== 48) begin n_err++; $display("FAIL full_bit_count: got %0d want 48", nbits); end
    n_cmp++; if (got !== exp_bits) begin n_err++; $display("FAIL full_stream: got %h want %h", got, exp_bits); end
    n_cmp++; if (stall_seen !== 1'b1) begin n_err++; $display("FAIL full_backpressure: got stall=%b want 1", stall_seen); end
    n_cmp++; if (last_cyc - first_cyc !== 47) begin n_err++; $display("FAIL full_contiguous: got span %0d want 47", last_cyc - first_cyc); end
    n_cmp++; if ({fe_cnt, fe_idx} !== {32'sd1, 32'sd47}) begin n_err++; $display("FAIL full_frame_end: got count %0d at %0d want 1 at 47", fe_cnt, fe_idx); end
    repeat (GAP_CYCLES + 1) @(negedge clk);
    n_cmp++; if ({busy, fifo_level} !== 4'b0000) begin n_err++; $display("FAIL full_drained: got busy=%b level=%0d want 0/0", busy, fifo_level); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] w;
    logic [2:0] obs, exp_v;
    w = 8'h3C;
    s_valid = 1'b1; s_data = 8'h11; s_last = 1'b0;
    @(negedge clk);
    s_data = 8'h22;
    @(negedge clk);
    s_data = 8'h33; s_last = 1'b1;
    @(negedge clk);
    drive_idle();
    repeat (10) @(negedge clk);
    // fourth bit of 8'h22 is on the wire, 8'h33 still queued
    obs = {bit_valid, bit_out, frame_end};
    n_cmp++; if (obs !== 3'b100) begin n_err++; $display("FAIL rmid_pre_bit: got v/b/fe=%b want 100", obs); end
    n_cmp++; if (fifo_level !== 3'd1) begin n_err++; $display("FAIL rmid_pre_level: got %0d want 1", fifo_level); end
    rst = 1'b1;
    #1;
    n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL rmid_async_valid: got %b want 0", bit_valid); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_err++; $display("FAIL rmid_async_level: got %0d want 0", fifo_level); end
    n_cmp++; if ({s_ready, busy, bit_out} !== 3'b100) begin n_err++; $display("FAIL rmid_async_misc: got rdy/busy/bit=%b want 100", {s_ready, busy, bit_out}); end
    @(negedge clk);
    rst = 1'b0;
    s_valid = 1'b1; s_data = w; s_last = 1'b1;
    @(negedge clk);
    drive_idle();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      obs = {bit_valid, bit_out, frame_end};
      exp_v = {1'b1, w[7-i], (i == 7)};
      n_cmp++; if (obs !== exp_v) begin n_err++; $display("FAIL rmid_bit%0d: got v/b/fe=%b want %b", i, obs, exp_v); end
    end
    for (int g = 0; g < int'(GAP_CYCLES) + 2; g++) begin
      @(negedge clk);
      n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL rmid_tail%0d: got valid=%b want 0", g, bit_valid); end
    end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_done_busy: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_underrun();
    test_fifo_full();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want completion before 200000ns");
    $fatal(1);
  end

endmodule
